fwd_ctrl: RTL and testbench
===========================

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Parameter RA_W, default 6, register-address width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 id_valid  input  1  ID stage holds a valid instruction this cycle.
REQ-005 id_rs  input  RA_W  source register A of the ID instruction.
REQ-006 id_rt  input  RA_W  source register B of the ID instruction.
REQ-007 id_rd  input  RA_W  destination register of the ID instruction.
REQ-008 id_regwrite  input  1  ID instruction writes id_rd.
REQ-009 id_memread  input  1  ID instruction is a load.
REQ-010 flush  input  1  squash the instruction advancing from ID to EX (taken branch/jump).
REQ-011 fwd_a_sel  output  2  registered select for the EX-stage operand-A 3:1 mux.
REQ-012 fwd_b_sel  output  2  registered select for the EX-stage operand-B 3:1 mux.
REQ-013 stall  output  1  combinational; hold PC and IF/ID, inject a bubble into EX.

Function
REQ-014 Select encoding SHALL be 00 = register-file operand, 01 = EX/MEM result, 10 = MEM/WB result; 11 SHALL never be driven.
REQ-015 The block SHALL keep two internal tag stages, EX and MEM, each holding {valid, regwrite, memread, rd}.
REQ-016 Each edge: MEM tag <= EX tag; EX tag <= ID fields when id_valid=1, stall=0, flush=0, otherwise EX tag <= bubble (valid=0, regwrite=0, memread=0).
REQ-017 fwd_a_sel SHALL register 01 if EX tag valid, regwrite=1, rd==id_rs; else 10 if MEM tag valid, regwrite=1, rd==id_rs; else 00.
REQ-018 fwd_b_sel SHALL follow REQ-017 with id_rt in place of id_rs.
REQ-019 When EX and MEM tags both match, the EX tag (newest producer) SHALL win, giving 01.
REQ-020 fwd_a_sel/fwd_b_sel SHALL load 00 on any edge where a bubble enters EX (stall, flush or id_valid=0).
REQ-021 stall SHALL be 1 iff id_valid=1 and EX tag valid, memread=1, regwrite=1, and rd equals id_rs or id_rt; otherwise 0.
REQ-022 A load-use stall SHALL last exactly one cycle: next cycle the load sits in the MEM tag and the held instruction receives select 10.
REQ-023 flush and stall asserted together: flush SHALL take priority for the EX tag (bubble); stall output is still driven per REQ-021.
REQ-024 Forwarding latency: selects SHALL be valid in the cycle the instruction occupies EX, one edge after it was presented in ID.

Reset
REQ-025 rst_n=0 SHALL immediately clear both tags to bubble and drive fwd_a_sel=00, fwd_b_sel=00, stall=0, independent of clk.
REQ-026 Reset deassertion mid-program SHALL resume with empty tags; no forwarding from pre-reset instructions.

Configuration
REQ-027 Macro FWD_ZERO_REG_EN defined: register 0 is hardwired zero; a tag with rd==0 SHALL never match, forward or cause a stall.
REQ-028 FWD_ZERO_REG_EN undefined: register 0 is treated like any other register in REQ-017 to REQ-021.

Verification
REQ-029 Reset: rst_n=0 mid-cycle with tags loaded -> selects 00, stall 0 without waiting for clk.
REQ-030 Back-to-back ALU: I1 rd=5 regwrite; next I2 rs=5 -> fwd_a_sel=01 while I2 in EX; I3 rt=5 one later -> fwd_b_sel=10.
REQ-031 Double producer: I1 rd=7, I2 rd=7, I3 rs=7 rt=7 -> fwd_a_sel=fwd_b_sel=01 (I2 wins).
REQ-032 Load-use: LD rd=3; next ADD rs=3 -> stall=1 for exactly one cycle, bubble in EX, then ADD in EX with fwd_a_sel=10.
REQ-033 Flush: I1 rd=4 presented with flush=1; next I2 rs=4 -> fwd_a_sel=00, stall=0.
REQ-034 Zero register: I1 rd=0 regwrite; I2 rs=0 -> 00 with FWD_ZERO_REG_EN defined, 01 without.

Source files
------------

// File: rtl/fwd_ctrl_if.sv
// rtl/fwd_ctrl_if.sv - ID-stage hazard bus between the decode stage and fwd_ctrl
interface fwd_ctrl_if #(
    parameter int RA_W = 6
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic [RA_W-1:0] id_rd;
    logic            id_regwrite;
    logic            id_memread;
    logic            flush;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic            stall;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, flush,
        input  fwd_a_sel, fwd_b_sel, stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, flush,
        output fwd_a_sel, fwd_b_sel, stall
    );
endinterface

// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - EX-stage forwarding select and load-use stall unit
// Optional macro FWD_ZERO_REG_EN: register 0 is hardwired zero and never forwards or stalls.
module fwd_ctrl #(
    parameter int RA_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    fwd_ctrl_if.slave  bus
);
    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic [RA_W-1:0] rd;
    } ex_tag_t;

    // Load status is only consulted while the producer sits in EX, so MEM drops it.
    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic [RA_W-1:0] rd;
    } mem_tag_t;

    ex_tag_t  ex_q,  ex_d;
    mem_tag_t mem_q, mem_d;
    logic [1:0] sel_a_q, sel_a_d;
    logic [1:0] sel_b_q, sel_b_d;
    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic load_use, advance;

    function automatic logic rd_hit(input logic [RA_W-1:0] rd, input logic [RA_W-1:0] src);
`ifdef FWD_ZERO_REG_EN
        return (rd == src) && (rd != '0);
`else
        return (rd == src);
`endif
    endfunction

    always_comb begin
        ex_hit_a  = ex_q.valid  & ex_q.regwrite  & rd_hit(ex_q.rd,  bus.id_rs);
        ex_hit_b  = ex_q.valid  & ex_q.regwrite  & rd_hit(ex_q.rd,  bus.id_rt);
        mem_hit_a = mem_q.valid & mem_q.regwrite & rd_hit(mem_q.rd, bus.id_rs);
        mem_hit_b = mem_q.valid & mem_q.regwrite & rd_hit(mem_q.rd, bus.id_rt);
        load_use  = bus.id_valid & ex_q.memread & (ex_hit_a | ex_hit_b);
        // Flush wins over stall: either way nothing enters EX this edge.
        advance   = bus.id_valid & ~load_use & ~bus.flush;
    end

    always_comb begin
        ex_d  = '0;
        mem_d = '{valid: ex_q.valid, regwrite: ex_q.regwrite, rd: ex_q.rd};
        sel_a_d = 2'b00;
        sel_b_d = 2'b00;
        if (advance) begin
            ex_d = '{valid: 1'b1, regwrite: bus.id_regwrite,
                     memread: bus.id_memread, rd: bus.id_rd};
            sel_a_d = ex_hit_a ? 2'b01 : (mem_hit_a ? 2'b10 : 2'b00);
            sel_b_d = ex_hit_b ? 2'b01 : (mem_hit_b ? 2'b10 : 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            sel_a_q <= 2'b00;
            sel_b_q <= 2'b00;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign bus.fwd_a_sel = sel_a_q;
    assign bus.fwd_b_sel = sel_b_q;
    assign bus.stall     = load_use;
endmodule

// File: tb/tb_fwd_ctrl.sv
// tb/tb_fwd_ctrl.sv - scoreboard bench for fwd_ctrl
module tb_fwd_ctrl;
    localparam int RA_W = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fwd_ctrl_if #(.RA_W(RA_W)) bus ();

    fwd_ctrl #(.RA_W(RA_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       valid;
        logic       rw;
        logic       mr;
        logic [5:0] rd;
    } tag_t;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
    } sel_t;

    sel_t exp_q[$];
    tag_t m_ex, m_mem;
    int   n_checks = 0;
    int   n_errors = 0;
    logic last_stall;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [5:0] rd, input logic [5:0] src);
`ifdef FWD_ZERO_REG_EN
        return (rd == src) && (rd != 6'd0);
`else
        return (rd == src);
`endif
    endfunction

    function automatic logic [1:0] m_sel(input logic adv, input logic [5:0] src);
        if (!adv) return 2'b00;
        if (m_ex.valid && m_ex.rw && m_hit(m_ex.rd, src)) return 2'b01;
        if (m_mem.valid && m_mem.rw && m_hit(m_mem.rd, src)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic drive(input logic v, input logic [5:0] rs, input logic [5:0] rt,
                         input logic [5:0] rd, input logic rw, input logic mr, input logic fl);
        bus.id_valid    = v;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.flush       = fl;
    endtask

    task automatic step(input logic v, input logic [5:0] rs, input logic [5:0] rt,
                        input logic [5:0] rd, input logic rw, input logic mr, input logic fl);
        sel_t e;
        logic es, adv;
        @(negedge clk);
        drive(v, rs, rt, rd, rw, mr, fl);
        #1;
        es = v & m_ex.valid & m_ex.mr & m_ex.rw & (m_hit(m_ex.rd, rs) | m_hit(m_ex.rd, rt));
        last_stall = bus.stall;
        check("stall", int'(bus.stall), int'(es));
        adv = v & ~es & ~fl;
        e.a = m_sel(adv, rs);
        e.b = m_sel(adv, rt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("fwd_a_sel", int'(bus.fwd_a_sel), int'(e.a));
        check("fwd_b_sel", int'(bus.fwd_b_sel), int'(e.b));
        m_mem = m_ex;
        m_ex  = adv ? '{valid: 1'b1, rw: rw, mr: mr, rd: rd} : '0;
    endtask

    task automatic idle();
        step(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m_ex  = '0;
        m_mem = '0;
        drive(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        check("reset_sel_a", int'(bus.fwd_a_sel), 0);
        check("reset_sel_b", int'(bus.fwd_b_sel), 0);
        check("reset_stall", int'(bus.stall), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ALU: EX/MEM then MEM/WB forwarding
        step(1'b1, 6'd1, 6'd2, 6'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 6'd5, 6'd8, 6'd9, 1'b0, 1'b0, 1'b0);
        check("b2b_i2_sel_a", int'(bus.fwd_a_sel), 1);
        step(1'b1, 6'd8, 6'd5, 6'd10, 1'b0, 1'b0, 1'b0);
        check("b2b_i3_sel_b", int'(bus.fwd_b_sel), 2);
        idle(); idle();

        // Double producer: newest wins
        step(1'b1, 6'd1, 6'd2, 6'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 6'd1, 6'd2, 6'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 6'd7, 6'd7, 6'd11, 1'b0, 1'b0, 1'b0);
        check("dbl_sel_a", int'(bus.fwd_a_sel), 1);
        check("dbl_sel_b", int'(bus.fwd_b_sel), 1);
        idle(); idle();

        // Load-use: one stall cycle, then MEM/WB forward
        step(1'b1, 6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 1'b0);
        step(1'b1, 6'd3, 6'd4, 6'd12, 1'b1, 1'b0, 1'b0);
        check("ld_use_stall", int'(last_stall), 1);
        check("ld_use_bubble_sel_a", int'(bus.fwd_a_sel), 0);
        step(1'b1, 6'd3, 6'd4, 6'd12, 1'b1, 1'b0, 1'b0);
        check("ld_use_release", int'(last_stall), 0);
        check("ld_use_sel_a", int'(bus.fwd_a_sel), 2);
        idle(); idle();

        // Flushed producer never forwards
        step(1'b1, 6'd1, 6'd2, 6'd4, 1'b1, 1'b0, 1'b1);
        step(1'b1, 6'd4, 6'd2, 6'd13, 1'b0, 1'b0, 1'b0);
        check("flush_sel_a", int'(bus.fwd_a_sel), 0);
        check("flush_stall", int'(last_stall), 0);
        idle(); idle();

        // Flush together with a load-use stall
        step(1'b1, 6'd1, 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
        step(1'b1, 6'd2, 6'd1, 6'd14, 1'b1, 1'b0, 1'b1);
        check("flush_stall_out", int'(last_stall), 1);
        step(1'b1, 6'd2, 6'd1, 6'd14, 1'b1, 1'b0, 1'b0);
        check("flush_stall_next_sel_a", int'(bus.fwd_a_sel), 2);
        idle(); idle();

        // Zero register
        step(1'b1, 6'd1, 6'd2, 6'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 6'd0, 6'd2, 6'd15, 1'b0, 1'b0, 1'b0);
`ifdef FWD_ZERO_REG_EN
        check("zero_reg_sel_a", int'(bus.fwd_a_sel), 0);
`else
        check("zero_reg_sel_a", int'(bus.fwd_a_sel), 1);
`endif
        idle(); idle();

        // Asynchronous reset with loaded tags and a pending stall
        step(1'b1, 6'd1, 6'd2, 6'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 6'd5, 6'd2, 6'd3, 1'b1, 1'b1, 1'b0);
        check("pre_rst_sel_a", int'(bus.fwd_a_sel), 1);
        @(negedge clk);
        drive(1'b1, 6'd3, 6'd2, 6'd16, 1'b1, 1'b0, 1'b0);
        #1;
        check("pre_rst_stall", int'(bus.stall), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_sel_a", int'(bus.fwd_a_sel), 0);
        check("async_rst_sel_b", int'(bus.fwd_b_sel), 0);
        check("async_rst_stall", int'(bus.stall), 0);
        m_ex  = '0;
        m_mem = '0;
        drive(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 6'd3, 6'd5, 6'd17, 1'b0, 1'b0, 1'b0);
        check("post_rst_sel_a", int'(bus.fwd_a_sel), 0);
        check("post_rst_sel_b", int'(bus.fwd_b_sel), 0);

        // Random instruction stream against the model
        for (int i = 0; i < 300; i++) begin
            logic       v, rw, mr, fl;
            logic [5:0] rs, rt, rd;
            v  = ($urandom_range(0, 9) != 0);
            rw = ($urandom_range(0, 3) != 0);
            mr = rw & ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 9) == 0);
            rs = 6'($urandom_range(0, 5));
            rt = 6'($urandom_range(0, 5));
            rd = 6'($urandom_range(0, 5));
            step(v, rs, rt, rd, rw, mr, fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
